// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - EX-stage multiply/divide sequencer driving an external multiplier and divider.
// Optional MDU_DIV0_FAST_EN: a zero divisor retires directly with hi=src_a, lo=all ones.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_div,
  input  logic        op_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;

  state_t      state;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        div0_fast;

`ifdef MDU_DIV0_FAST_EN
  assign div0_fast = op_div && (src_b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && !flush) begin
            if (!op_div) begin
              state <= MUL_WAIT;
            end else if (div0_fast) begin
              state <= DONE;
              hi_q  <= src_a;
              lo_q  <= 32'hFFFF_FFFF;
            end else begin
              state <= DIV_RUN;
            end
          end
        end
        MUL_WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi_q  <= mul_result[63:32];
            lo_q  <= mul_result[31:0];
            state <= DONE;
          end
        end
        // flush wins over a divider completion arriving in the same cycle
        DIV_RUN: begin
          if (flush) begin
            state <= IDLE;
          end else if (div_ready) begin
            hi_q  <= div_result[63:32];
            lo_q  <= div_result[31:0];
            state <= DONE;
          end
        end
        DONE: begin
          if (flush || !ex_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq   = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_opa    = 32'd0;
    div_opb    = 32'd0;
    div_annul  = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = 32'd0;
    lo_wdata   = 32'd0;
    mul_signed = op_signed;
    busy       = (state != IDLE);
    case (state)
      IDLE:     stallreq = op_valid && !flush;
      MUL_WAIT: stallreq = 1'b1;
      DIV_RUN: begin
        stallreq   = 1'b1;
        div_start  = !div_ready && !flush;
        div_signed = op_signed;
        div_opa    = src_a;
        div_opb    = src_b;
        div_annul  = flush;
      end
      DONE: begin
        hi_we    = !ex_hold && !flush;
        lo_we    = !ex_hold && !flush;
        hi_wdata = hi_q;
        lo_wdata = lo_q;
      end
      default: stallreq = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with behavioural multiplier/divider models.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_div, op_signed, flush, ex_hold;
  logic [31:0] src_a, src_b;
  logic        div_start, div_signed, div_annul, div_ready, mul_signed;
  logic [31:0] div_opa, div_opb, hi_wdata, lo_wdata;
  logic [63:0] div_result, mul_result;
  logic        stallreq, hi_we, lo_we, busy;

  int checks = 0;
  int errors = 0;
  int div_lat = 4;
  int dv_cnt;
  logic dv_rdy;
  logic spur = 1'b0;

`ifdef MDU_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_div(op_div), .op_signed(op_signed),
    .src_a(src_a), .src_b(src_b), .flush(flush), .ex_hold(ex_hold),
    .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .mul_signed(mul_signed), .mul_result(mul_result), .stallreq(stallreq),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
  );

  // External multiplier: product registered one cycle after operands
  always @(posedge clk)
    if (mul_signed) mul_result <= $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    else            mul_result <= {32'd0, src_a} * {32'd0, src_b};

  // External divider: ready in the div_lat-th cycle of continuous start
  function automatic logic [63:0] div_model(input logic [31:0] a, b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk) begin
    if (rst || div_annul || !div_start) begin
      dv_cnt <= 0;
      dv_rdy <= 1'b0;
    end else begin
      dv_cnt     <= dv_cnt + 1;
      dv_rdy     <= (dv_cnt + 1 == div_lat - 1);
      div_result <= div_model(div_opa, div_opb, div_signed);
    end
  end
  assign div_ready = dv_rdy | spur;

  // Reference result from sign/magnitude arithmetic
  function automatic logic [63:0] ref_res(input bit d, s, input logic [31:0] a, b);
    logic [31:0] ua, ub, q, r;
    if (!d) begin
      if (s) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    q = ua / ub;
    r = ua % ub;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit d, s, input logic [31:0] a, b, input int lat, hold,
                        input logic [63:0] exp, input string tag);
    bit f0;
    int st, ns, bad;
    f0 = FAST && d && (b == 32'd0);
    st = 0; ns = 0; bad = 0;
    div_lat = lat;
    op_valid = 1'b1; op_div = d; op_signed = s; src_a = a; src_b = b;
    #1;
    chk({tag, ".mul_signed"}, 64'(mul_signed), 64'(s));
    while (stallreq === 1'b1 && st < 300) begin
      st++;
      if (div_start) begin
        ns++;
        if (div_signed !== s || div_opa !== a || div_opb !== b) bad++;
      end
      if (hi_we || lo_we) bad++;
      cyc();
    end
    chk({tag, ".stall"}, 64'(st), d ? (f0 ? 64'd1 : 64'(lat + 1)) : 64'd2);
    chk({tag, ".starts"}, 64'(ns), (d && !f0) ? 64'(lat - 1) : 64'd0);
    chk({tag, ".bad"}, 64'(bad), 64'd0);
    for (int h = 0; h < hold; h++) begin
      ex_hold = 1'b1;
      #1;
      chk({tag, ".held_we"}, {62'd0, hi_we, lo_we}, 64'd0);
      chk({tag, ".held_busy"}, 64'(busy), 64'd1);
      cyc();
    end
    ex_hold = 1'b0;
    #1;
    chk({tag, ".we"}, {62'd0, hi_we, lo_we}, 64'd3);
    chk({tag, ".data"}, {hi_wdata, lo_wdata}, exp);
    cyc();
    op_valid = 1'b0;
    #1;
    chk({tag, ".idle"}, {62'd0, busy, hi_we}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rd, rs;
    rst = 1'b1; op_valid = 1'b0; op_div = 1'b0; op_signed = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    src_a = 32'd0; src_b = 32'd0;
    cyc(); cyc();
    chk("reset.ctl", {56'd0, stallreq, busy, div_start, div_annul, hi_we, lo_we, div_signed, mul_signed}, 64'd0);
    chk("reset.wdata", {hi_wdata, lo_wdata}, 64'd0);
    chk("reset.divop", {div_opa, div_opb}, 64'd0);
    rst = 1'b0;
    cyc();

    run_op(0, 0, 32'hFFFF_FFFF, 32'd2, 2, 0, 64'h0000_0001_FFFF_FFFE, "multu_max");
    run_op(1, 1, -32'sd7, 32'd2, 32, 0, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg7");
    run_op(0, 1, 32'd3, 32'd4, 2, 3, 64'd12, "mult_hold");
    run_op(1, 0, 32'd5, 32'd0, 6, 0, 64'h0000_0005_FFFF_FFFF, "divu_zero");

    // Flush in DIV_RUN cycle 5, coinciding with divider completion
    div_lat = 5;
    op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b0; src_a = 32'd100; src_b = 32'd7;
    for (int i = 0; i < 5; i++) cyc();
    flush = 1'b1;
    #1;
    chk("flush_div.annul", 64'(div_annul), 64'd1);
    chk("flush_div.we", {62'd0, hi_we, lo_we}, 64'd0);
    cyc();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flush_div.idle", {61'd0, busy, div_annul, hi_we}, 64'd0);
    run_op(1, 0, 32'd9, 32'd3, 4, 0, 64'd3, "divu_after_flush");

    // Flush in MUL_WAIT and in DONE
    for (int k = 1; k <= 2; k++) begin
      op_valid = 1'b1; op_div = 1'b0; op_signed = 1'b0; src_a = 32'd6; src_b = 32'd7;
      for (int i = 0; i < k; i++) cyc();
      flush = 1'b1;
      #1;
      chk("flush_mul.we", {62'd0, hi_we, lo_we}, 64'd0);
      cyc();
      flush = 1'b0; op_valid = 1'b0;
      #1;
      chk("flush_mul.idle", {62'd0, busy, hi_we}, 64'd0);
    end

    // Flush in IDLE suppresses acceptance
    op_valid = 1'b1; op_div = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle.stall", 64'(stallreq), 64'd0);
    cyc();
    chk("flush_idle.busy", 64'(busy), 64'd0);
    flush = 1'b0; op_valid = 1'b0;

    // Stray div_ready while idle
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    #1;
    chk("spur.idle", {61'd0, busy, hi_we, stallreq}, 64'd0);

    // Reset during DIV_RUN
    div_lat = 32;
    op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b0; src_a = 32'd50; src_b = 32'd5;
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b1; op_valid = 1'b0;
    cyc();
    chk("rst_div.ctl", {60'd0, busy, stallreq, hi_we, div_start}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_div.nowrite", {62'd0, hi_we, busy}, 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op(rd, rs, ra, rb, $urandom_range(2, 8), $urandom_range(0, 2), ref_res(rd, rs, ra, rb), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
